// File: rtl/edram_pkg.sv
// Shared constants and slot types for the edram slot scheduler.
// One slot is PHASES clk cycles of the macro.
package edram_pkg;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 343;
    localparam int PHASES = 4;

    typedef enum logic [1:0] {
        SLOT_IDLE,
        SLOT_RD,
        SLOT_WR,
        SLOT_REF
    } slot_e;
endpackage

// File: rtl/edram_ref_timer.sv
// Refresh bookkeeping: interval credits, pending debt, refresh row,
// sticky overflow and the short history of recently refreshed rows.
module edram_ref_timer
    import edram_pkg::*;
#(
    parameter int REF_INTERVAL = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              ref_go,
    input  logic [ADDR_W-1:0] chk_addr,
    output logic [2:0]        pending,
    output logic [ADDR_W-1:0] ref_addr,
    output logic              overflow,
    output logic              hazard
);
    localparam logic [15:0] IV_LAST = 16'(REF_INTERVAL - 1);

    logic [15:0]             iv_cnt;
    logic                    credit;
    logic [2:0]              hist_v;
    logic [2:0][ADDR_W-1:0]  hist_a;

    assign credit = (iv_cnt == IV_LAST);

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (hist_v[i] && (hist_a[i] == chk_addr)) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iv_cnt   <= '0;
            pending  <= '0;
            ref_addr <= '0;
            overflow <= 1'b0;
            hist_v   <= '0;
            hist_a   <= '0;
        end else if (tick) begin
            iv_cnt <= credit ? '0 : iv_cnt + 1'b1;
            // a credit and a refresh in the same slot cancel out
            if (credit && !ref_go) begin
                if (pending == 3'd7) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + 1'b1;
                end
            end else if (!credit && ref_go) begin
                pending <= pending - 1'b1;
            end
            if (ref_go) begin
                ref_addr <= ref_addr + 1'b1;
            end
            hist_v <= {hist_v[1:0], ref_go};
            hist_a <= {hist_a[1:0], ref_addr};
        end
    end
endmodule

// File: rtl/edram_sched.sv
// Slot arbiter for one edram macro: picks read/write/refresh/idle every
// PHASES clk, drives the macro ports and returns read data after RD_LAT slots.
module edram_sched
    import edram_pkg::*;
#(
    parameter int REF_INTERVAL = 64,
    parameter int REF_URGENT   = 4,
    parameter int RD_LAT       = 4,
    parameter int WR_AGE       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    output logic              port_en,
    output logic              port_ref_plus2,
    output logic [ADDR_W-1:0] port_read_addr,
    output logic [ADDR_W-1:0] port_write_addr,
    output logic [DATA_W-1:0] port_write_data,
    output logic              port_wen_plus3,
    input  logic [DATA_W-1:0] mem_read_data,
    output logic              ref_overflow
);
    localparam logic [1:0] LAST_PH = 2'(PHASES - 1);
    localparam logic [3:0] URG     = 4'(REF_URGENT);
    localparam logic [2:0] AGE_MAX = 3'(WR_AGE);

    logic [1:0]        phase;
    logic              tick;
    slot_e             slot;
    slot_e             nxt;
    logic [2:0]        pending;
    logic [2:0]        age;
    logic [ADDR_W-1:0] ref_addr;
    logic              hazard;
    logic              wr_ok;
    logic              urgent;
    logic              ref_go;
    logic [RD_LAT-1:0] rd_pipe;

    assign tick   = (phase == 2'd0);
    assign wr_ok  = wr_req && !hazard;
    assign urgent = ({1'b0, pending} >= URG) && (pending != 3'd0);
    assign ref_go = tick && (nxt == SLOT_REF);

    edram_ref_timer #(
        .REF_INTERVAL(REF_INTERVAL)
    ) u_timer (
        .clk     (clk),
        .rst     (rst),
        .tick    (tick),
        .ref_go  (ref_go),
        .chk_addr(wr_addr),
        .pending (pending),
        .ref_addr(ref_addr),
        .overflow(ref_overflow),
        .hazard  (hazard)
    );

    always_comb begin
        nxt = SLOT_IDLE;
        if (urgent) begin
            nxt = SLOT_REF;
        end else if (wr_ok && (age == AGE_MAX)) begin
            nxt = SLOT_WR;
        end else if (rd_req) begin
            nxt = SLOT_RD;
        end else if (wr_ok) begin
            nxt = SLOT_WR;
        end else if (pending != 3'd0) begin
            nxt = SLOT_REF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase           <= '0;
            slot            <= SLOT_IDLE;
            age             <= '0;
            rd_pipe         <= '0;
            rd_gnt          <= 1'b0;
            wr_gnt          <= 1'b0;
            rd_valid        <= 1'b0;
            rd_data         <= '0;
            port_en         <= 1'b0;
            port_ref_plus2  <= 1'b0;
            port_read_addr  <= '0;
            port_write_addr <= '0;
            port_write_data <= '0;
            port_wen_plus3  <= 1'b0;
        end else begin
            phase          <= phase + 1'b1;
            rd_gnt         <= 1'b0;
            wr_gnt         <= 1'b0;
            rd_valid       <= 1'b0;
            port_wen_plus3 <= (phase == LAST_PH) && (slot == SLOT_WR);
            if (tick) begin
                slot           <= nxt;
                rd_gnt         <= (nxt == SLOT_RD);
                wr_gnt         <= (nxt == SLOT_WR);
                port_en        <= (nxt == SLOT_RD);
                port_ref_plus2 <= (nxt == SLOT_REF);
                rd_pipe        <= {rd_pipe[RD_LAT-2:0], nxt == SLOT_RD};
                rd_valid       <= rd_pipe[RD_LAT-1];
                if (rd_pipe[RD_LAT-1]) begin
                    rd_data <= mem_read_data;
                end
                if (nxt == SLOT_RD) begin
                    port_read_addr <= rd_addr;
                end
                if (nxt == SLOT_REF) begin
                    port_read_addr <= ref_addr;
                end
                if (nxt == SLOT_WR) begin
                    port_write_addr <= wr_addr;
                    port_write_data <= wr_data;
                end
                if (!wr_req || (nxt == SLOT_WR)) begin
                    age <= '0;
                end else if (age != AGE_MAX) begin
                    age <= age + 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/edram_sched.md
Name: edram_sched

Overview:
- Slot scheduler and arbiter for one edram macro (512 rows x 343 bits).
- One macro "cycle" (slot) is four clk cycles. The scheduler decides the owner of each slot: host read, host write, row refresh, or idle.
- Drives the macro control/address/data ports, tracks refresh debt and read latency, and returns read data with a valid strobe.

Parameters:
- ADDR_W, 9, row address width (rows = 2^ADDR_W)
- DATA_W, 343, row data width
- REF_INTERVAL, 64, slots between refresh credits
- REF_URGENT, 4, pending-refresh level at which refresh preempts host traffic
- RD_LAT, 4, slots from read issue to data valid on mem_read_data
- WR_AGE, 4, consecutive lost slots after which a write outranks reads

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rd_req  in  1  host read request, held until rd_gnt
- rd_addr  in  ADDR_W  read row, stable while rd_req
- rd_gnt  out  1  one-clk grant pulse
- rd_valid  out  1  one-clk read data valid
- rd_data  out  DATA_W  read data, registered
- wr_req  in  1  host write request, held until wr_gnt
- wr_addr  in  ADDR_W  write row
- wr_data  in  DATA_W  write data
- wr_gnt  out  1  one-clk grant pulse
- port_en  out  1  macro read strobe
- port_ref_plus2  out  1  macro refresh strobe
- port_read_addr  out  ADDR_W  macro read/refresh row
- port_write_addr  out  ADDR_W  macro write row
- port_write_data  out  DATA_W  macro write data
- port_wen_plus3  out  1  macro write enable
- mem_read_data  in  DATA_W  macro read output
- ref_overflow  out  1  sticky: refresh debt saturated

Behaviour:
- Reset (async, any time):
  - phase=0, all outputs 0, pending=0, ref_addr=0, interval counter=0, write age=0, read pipeline cleared.
  - In-flight reads are dropped; no rd_valid is produced for them.
- Phase counter 0..3 wraps. Arbitration happens only on the clk where phase==0. The first decision is on the first clk edge after rst deasserts.
- Priority at phase 0:
  1. urgent refresh (pending>=REF_URGENT)
  2. aged write (age>=WR_AGE)
  3. read
  4. write
  5. refresh (pending>0)
  6. idle
- Write hazard: a write to a row equal to a refresh row issued in the previous 3 slots is ineligible. The next eligible class wins instead. A read to the same row is never blocked.
- Read slot:
  - rd_gnt=1 for the phase-0 clk.
  - port_en=1 and port_read_addr=rd_addr for phases 0..3.
- Write slot:
  - wr_gnt=1 at phase 0.
  - port_write_addr and port_write_data are latched at phase 0 and held for the slot.
  - port_wen_plus3=1 on phase 3 only.
- Refresh slot:
  - port_ref_plus2=1 and port_read_addr=ref_addr for phases 0..3.
  - ref_addr increments at the end of the slot, wrapping 511->0.
  - pending decrements.
  - The row is recorded in a 3-deep hazard history.
- Idle slot: all strobes 0. Address outputs hold their last value.
- Interval counter:
  - Counts slots.
  - At REF_INTERVAL-1 it wraps to 0 and pending increments.
  - pending saturates at 7; a credit lost at saturation sets ref_overflow, cleared only by rst.
  - An increment and a decrement in the same slot leave pending unchanged.
- Write age:
  - Increments each slot in which wr_req=1 and the write is not granted, saturating at WR_AGE.
  - Cleared on wr_gnt or when wr_req=0.
- Read return:
  - A read issued in slot S gives rd_valid=1 at the phase-0 clk of slot S+RD_LAT, exactly 4*RD_LAT clk after rd_gnt.
  - rd_data is captured from mem_read_data on that clk and holds until the next rd_valid.
- rd_gnt and wr_gnt are never both high. At most one grant or refresh per slot.

Decomposition:
- Shared package edram_pkg: ADDR_W and DATA_W constants, slot-type enum {SLOT_IDLE, SLOT_RD, SLOT_WR, SLOT_REF}, phase-count constant 4.
- One sub-module, edram_ref_timer, holds the interval counter, pending counter, ref_addr, overflow and hazard history.
- Arbitration, the port drivers and the read-return shift register stay in edram_sched.

Test Plan:
- Reset, then rd_req with rd_addr=0x0A5:
  - rd_gnt at the first phase 0.
  - port_en high 4 clk with port_read_addr=0x0A5.
  - rd_valid exactly 16 clk after rd_gnt, rd_data=mem_read_data at that clk.
- wr_req with wr_addr=0x1FF, wr_data=pattern:
  - wr_gnt at phase 0.
  - port_wen_plus3 high only at phase 3, with addr 0x1FF and data equal to the pattern.
- Idle for 64 slots:
  - One refresh with port_ref_plus2, port_read_addr=0.
  - ref_addr becomes 1 and pending returns to 0.
  - After 512 refreshes, ref_addr wraps to 0.
- rd_req held constantly for 4*64 slots:
  - At pending=4, a refresh preempts the read.
  - A concurrent wr_req is granted at the latest in its 5th contended slot (age 4).
- Refresh of row 0x010, then wr_req to 0x010 in the next slot:
  - Write is withheld for 3 slots and granted in the 4th.
  - A pending read to 0x010 is granted during the window.
- Assert rst with 2 reads in flight:
  - Outputs 0 immediately.
  - No rd_valid after release; pending=0.
  - Block saturated past pending=7 with no slots available sets ref_overflow=1, cleared only by rst.
